// File: rtl/mc_sequencer_if.sv
// Bus between the multicycle control sequencer and the datapath it steers.
// The master side is the sequencer; the slave side is the datapath.
interface mc_sequencer_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        AdrSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  State;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle ARM-subset control sequencer: Moore state decode, condition
// evaluation against a registered NZCV flags register, and memory handshaking.
module mc_sequencer (
    input  logic           clk,
    input  logic           reset,
    mc_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t      state;
    logic [3:0]  flags;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        instr_unused;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        cond_ex;
    logic [1:0]  alu_ctrl;
    logic        is_cmp;
    logic        cv_op;

    assign cond         = bus.Instr[19:16];
    assign op           = bus.Instr[15:14];
    assign funct        = bus.Instr[13:8];
    assign rd           = bus.Instr[3:0];
    assign instr_unused = ^bus.Instr[7:4];

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = !flag_v;
            4'b1000: cond_ex = flag_c && !flag_z;
            4'b1001: cond_ex = !flag_c || flag_z;
            4'b1010: cond_ex = !(flag_n ^ flag_v);
            4'b1011: cond_ex = flag_n ^ flag_v;
            4'b1100: cond_ex = !flag_z && !(flag_n ^ flag_v);
            4'b1101: cond_ex = flag_z || (flag_n ^ flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl = 2'b00;
        case (funct[4:1])
            4'b0100: alu_ctrl = 2'b00;
            4'b0010: alu_ctrl = 2'b01;
            4'b0000: alu_ctrl = 2'b10;
            4'b1100: alu_ctrl = 2'b11;
            4'b1010: alu_ctrl = 2'b01;
            default: alu_ctrl = 2'b00;
        endcase
    end

    assign is_cmp = (funct[4:1] == 4'b1010);
    assign cv_op  = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010) || is_cmp;

    // A failed condition in MEMRD/MEMWR abandons the access after one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            flags <= 4'b0000;
        end else begin
            case (state)
                FETCH:  if (bus.MemReady) state <= DECODE;
                DECODE: begin
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECI : EXECR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= funct[0] ? MEMRD : MEMWR;
                MEMRD: begin
                    if (!cond_ex)          state <= FETCH;
                    else if (bus.MemReady) state <= MEMWB;
                end
                MEMWB:  state <= FETCH;
                MEMWR:  if (!cond_ex || bus.MemReady) state <= FETCH;
                EXECR, EXECI: begin
                    state <= ALUWB;
                    if (funct[0] && cond_ex) begin
                        flags[3:2] <= bus.ALUFlags[3:2];
                        if (cv_op) flags[1:0] <= bus.ALUFlags[1:0];
                    end
                end
                ALUWB:   state <= FETCH;
                BRANCH:  state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.State = state;

    // Reset forces every strobe and select low without waiting for a clock edge.
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.RegSrc     = 2'b00;
        bus.ALUControl = 2'b00;
        if (reset) begin
            bus.ImmSrc = op;
            bus.RegSrc = {(op == 2'b01) && !funct[0], op == 2'b10};
            case (state)
                FETCH: begin
                    bus.ALUSrcA   = 2'b01;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                    bus.IRWrite   = bus.MemReady;
                    bus.PCWrite   = bus.MemReady;
                end
                DECODE: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b10;
                end
                MEMADR: begin
                    bus.ALUSrcB    = 2'b01;
                    bus.ALUControl = funct[3] ? 2'b00 : 2'b01;
                end
                MEMRD: bus.AdrSrc = 1'b1;
                MEMWB: begin
                    bus.ResultSrc = 2'b01;
                    bus.RegWrite  = cond_ex;
                end
                MEMWR: begin
                    bus.AdrSrc   = 1'b1;
                    bus.MemWrite = cond_ex;
                end
                EXECR: bus.ALUControl = alu_ctrl;
                EXECI: begin
                    bus.ALUSrcB    = 2'b01;
                    bus.ALUControl = alu_ctrl;
                end
                ALUWB: begin
                    bus.RegWrite = cond_ex && !is_cmp;
                    bus.PCWrite  = cond_ex && (rd == 4'hF) && !is_cmp;
                end
                BRANCH: begin
                    bus.ALUSrcA   = 2'b10;
                    bus.ALUSrcB   = 2'b01;
                    bus.ResultSrc = 2'b10;
                    bus.PCWrite   = cond_ex;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_sequencer.sv
// Randomised instruction-level bench for mc_sequencer against a cycle-by-cycle
// reference built from the instruction semantics and an NZCV flag model.
module tb_mc_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    logic [3:0]  flags_m = 4'b0000;
    logic [19:0] cur_instr = 20'h0;

    always #5 clk = ~clk;

    mc_sequencer_if ifc ();

    mc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (instr %05h, t=%0t)",
                     tag, obs, exp, cur_instr, $time);
        end
    endtask

    function automatic logic [19:0] make_instr(input logic [3:0] c, input logic [1:0] o,
                                               input logic [5:0] f, input logic [3:0] r);
        return {c, o, f, 4'h0, r};
    endfunction

    // Condition as a base test on Cond[3:1], inverted by Cond[0]
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !b : b;
    endfunction

    function automatic logic [1:0] ref_alu(input logic [5:0] f);
        case (f[4:1])
            4'b0100: return 2'd0;
            4'b0010: return 2'd1;
            4'b0000: return 2'd2;
            4'b1100: return 2'd3;
            4'b1010: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} expected in each state
    function automatic logic [8:0] ref_sel(input int st, input logic [19:0] ins);
        logic [5:0] f;
        f = ins[13:8];
        case (st)
            0: return {1'b0, 2'b01, 2'b10, 2'b10, 2'b00};
            1: return {1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
            2: return {1'b0, 2'b00, 2'b01, 2'b00, f[3] ? 2'b00 : 2'b01};
            3: return {1'b1, 8'h00};
            4: return {1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
            5: return {1'b1, 8'h00};
            6: return {7'h00, ref_alu(f)};
            7: return {1'b0, 2'b00, 2'b01, 2'b00, ref_alu(f)};
            9: return {1'b0, 2'b10, 2'b01, 2'b10, 2'b00};
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [3:0] ref_ext(input logic [19:0] ins);
        logic [1:0] o;
        o = ins[15:14];
        return {o, (o == 2'b01) && !ins[8], o == 2'b10};
    endfunction

    // Drive one cycle's inputs, check at the falling edge, return to posedge+1
    task automatic apply_stimulus(input int st, input logic [3:0] strb,
                                  input logic mr, input logic [3:0] af);
        ifc.MemReady = mr;
        ifc.ALUFlags = af;
        @(negedge clk);
        check_output("state", 16'(ifc.State), 16'(st));
        check_output("strobes", 16'({ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.MemWrite}), 16'(strb));
        check_output("selects", 16'({ifc.AdrSrc, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ResultSrc, ifc.ALUControl}),
                     16'(ref_sel(st, cur_instr)));
        check_output("imm_regsrc", 16'({ifc.ImmSrc, ifc.RegSrc}), 16'(ref_ext(cur_instr)));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_state"}, 16'(ifc.State), 16'd0);
        check_output({tag, "_strobes"}, 16'({ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.MemWrite}), 16'd0);
        check_output({tag, "_selects"}, 16'({ifc.AdrSrc, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ResultSrc,
                                             ifc.ALUControl, ifc.ImmSrc, ifc.RegSrc}), 16'd0);
    endtask

    // Runs one complete instruction from FETCH, predicting every cycle
    task automatic run_instr(input logic [19:0] ins, input int fd, input int md, input logic [3:0] af);
        logic [3:0] c, r;
        logic [1:0] o;
        logic [5:0] f;
        logic ce, cmp;
        cur_instr = ins;
        ifc.Instr = ins;
        {c, o, f} = ins[19:8];
        r = ins[3:0];
        for (int k = 0; k <= fd; k++) begin
            logic mr;
            mr = (k == fd);
            apply_stimulus(0, {mr, mr, 2'b00}, mr, 4'($urandom));
        end
        apply_stimulus(1, 4'b0000, 1'($urandom), 4'($urandom));
        ce = ref_cond(c, flags_m);
        case (o)
            2'b10: apply_stimulus(9, {ce, 3'b000}, 1'($urandom), 4'($urandom));
            2'b00: begin
                apply_stimulus(f[5] ? 7 : 6, 4'b0000, 1'($urandom), af);
                if (f[0] && ce) begin
                    flags_m[3:2] = af[3:2];
                    if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010)
                        flags_m[1:0] = af[1:0];
                end
                ce  = ref_cond(c, flags_m);
                cmp = (f[4:1] == 4'b1010);
                apply_stimulus(8, {ce && r == 4'hF && !cmp, 1'b0, ce && !cmp, 1'b0},
                               1'($urandom), 4'($urandom));
            end
            2'b01: begin
                apply_stimulus(2, 4'b0000, 1'($urandom), 4'($urandom));
                if (!ce) begin
                    apply_stimulus(f[0] ? 3 : 5, 4'b0000, 1'($urandom), 4'($urandom));
                end else begin
                    for (int k = 0; k <= md; k++)
                        apply_stimulus(f[0] ? 3 : 5, {3'b000, !f[0]}, k == md, 4'($urandom));
                    if (f[0]) apply_stimulus(4, 4'b0010, 1'($urandom), 4'($urandom));
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [19:0] ins;
        cur_instr    = make_instr(4'hE, 2'b10, 6'b000000, 4'h0);
        ifc.Instr    = cur_instr;
        ifc.MemReady = 1'b1;
        ifc.ALUFlags = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        reset = 1'b1;
        apply_stimulus(0, 4'b0000, 1'b0, 4'h0);
        apply_stimulus(0, 4'b0000, 1'b0, 4'h0);

        // ADD, STR with slow memory, CMP then BNE/BEQ, LDR that fails its condition
        run_instr(make_instr(4'hE, 2'b00, 6'b001000, 4'h1), 0, 0, 4'h0);
        run_instr(make_instr(4'hE, 2'b01, 6'b011000, 4'h2), 0, 3, 4'h0);
        run_instr(make_instr(4'hE, 2'b00, 6'b010101, 4'h0), 0, 0, 4'b0100);
        run_instr(make_instr(4'h1, 2'b10, 6'b000000, 4'h0), 0, 0, 4'h0);
        run_instr(make_instr(4'h0, 2'b10, 6'b000000, 4'h0), 0, 0, 4'h0);
        run_instr(make_instr(4'hE, 2'b00, 6'b010101, 4'h0), 0, 0, 4'b0000);
        run_instr(make_instr(4'h0, 2'b01, 6'b011001, 4'h3), 1, 2, 4'h0);
        run_instr(make_instr(4'hE, 2'b00, 6'b101001, 4'hF), 2, 0, 4'h0);

        // Abort a pending store with reset, flags set beforehand so clearing is visible
        run_instr(make_instr(4'hE, 2'b00, 6'b010101, 4'h0), 0, 0, 4'hF);
        cur_instr = make_instr(4'hE, 2'b01, 6'b011000, 4'h0);
        ifc.Instr = cur_instr;
        apply_stimulus(0, 4'b1100, 1'b1, 4'h0);
        apply_stimulus(1, 4'b0000, 1'b0, 4'h0);
        apply_stimulus(2, 4'b0000, 1'b0, 4'h0);
        apply_stimulus(5, 4'b0001, 1'b0, 4'h0);
        ifc.MemReady = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_abort");
        flags_m = 4'b0000;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_edge");
        reset = 1'b1;
        apply_stimulus(0, 4'b0000, 1'b0, 4'h0);
        apply_stimulus(0, 4'b0000, 1'b0, 4'h0);
        run_instr(make_instr(4'h0, 2'b10, 6'b000000, 4'h0), 0, 0, 4'h0);
        run_instr(make_instr(4'h1, 2'b10, 6'b000000, 4'h0), 0, 0, 4'h0);
        run_instr(make_instr(4'h4, 2'b10, 6'b000000, 4'h0), 0, 0, 4'h0);

        // Every condition code against every flag pattern
        for (int fv = 0; fv < 16; fv++) begin
            run_instr(make_instr(4'hE, 2'b00, 6'b010101, 4'h0), 0, 0, 4'(fv));
            for (int cv = 0; cv < 16; cv++)
                run_instr(make_instr(4'(cv), 2'b10, 6'($urandom), 4'($urandom)), 0, 0, 4'h0);
        end

        for (int i = 0; i < 250; i++) begin
            ins = 20'($urandom);
            ins[7:4] = 4'h0;
            if ($urandom_range(0, 2) != 0) ins[19:16] = 4'hE;
            if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have no parameters; state encoding is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Instr  input  20  instruction bits [31:12] from the instruction register: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
REQ-005 ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-006 MemReady  input  1  memory completes the access presented this cycle.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  PC enable, IR enable, register file write, memory write, address mux select (0=PC, 1=ALU result register).
REQ-008 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  output  2 each  datapath mux, extend and ALU selects.
REQ-009 State  output  4  current state, for debug.

Function
REQ-010 SHALL implement 10 states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-011 FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=00, ResultSrc=10; IRWrite=PCWrite=1 only in the cycle MemReady=1, then go to DECODE; otherwise hold FETCH.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=00. Next state: Op=01 -> MEMADR; Op=00 with Funct[5]=1 -> EXECI; Op=00 with Funct[5]=0 -> EXECR; Op=10 -> BRANCH; Op=11 -> FETCH.
REQ-013 MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl = Funct[3] ? 00 : 01. Next state is MEMRD when Funct[0]=1, otherwise MEMWR.
REQ-014 MEMRD: AdrSrc=1; hold until MemReady=1, then go to MEMWB. MEMWB: ResultSrc=01, RegWrite=CondEx, next state FETCH.
REQ-015 MEMWR: AdrSrc=1, MemWrite=CondEx; hold until MemReady=1, then go to FETCH.
REQ-016 In MEMRD and MEMWR, if CondEx=0, the block SHALL go to FETCH in one cycle, assert no memory strobe, and ignore MemReady.
REQ-017 EXECR uses ALUSrcB=00; EXECI uses ALUSrcB=01. Both use ALUSrcA=00, and both go to ALUWB.
REQ-018 ALU decode for Funct[4:1]: 0100->00 (ADD), 0010->01 (SUB), 0000->10 (AND), 1100->11 (ORR), 1010->01 (CMP); any other value -> 00.
REQ-019 ALUWB: ResultSrc=00. RegWrite=CondEx and not CMP. PCWrite=CondEx and Rd=1111 and not CMP. Next state FETCH.
REQ-020 BRANCH: ALUSrcA=10, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondEx, next state FETCH.
REQ-021 ImmSrc = Op in all states; RegSrc[0]=(Op=10); RegSrc[1]=(Op=01 and Funct[0]=0).
REQ-022 A 4-bit Flags register {N,Z,C,V} SHALL update at the end of EXECR/EXECI when Funct[0]=1 (S bit, or CMP) and CondEx=1:
  - NZ update from ALUFlags[3:2] for every ALU op.
  - CV update from ALUFlags[1:0] only for ADD, SUB or CMP.
REQ-023 CondEx SHALL be evaluated from the registered Flags, not from ALUFlags. Supported Cond values: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Cond=1111 evaluates false.
REQ-024 All strobes (PCWrite, IRWrite, RegWrite, MemWrite) SHALL be 0 in any state or cycle not named above; all unspecified selects SHALL be 00.
REQ-025 Outputs are Moore-style except for the MemReady and CondEx qualification; there is no combinational path from MemReady to any select output.

Reset
REQ-026 While reset=0: State=FETCH, Flags=0000, all strobes 0, all selects 00; this SHALL apply immediately, without a clock edge.
REQ-027 Reset asserted mid-access (MEMRD/MEMWR waiting on MemReady) SHALL abort the access: MemWrite drops in the same cycle, and after release the block restarts at FETCH.
REQ-028 The first FETCH after reset release SHALL wait for MemReady like any other fetch.

Verification
REQ-029 ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000), MemReady=1 -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; 4 cycles per instruction.
REQ-030 STR (Op=01, Funct=011000), MemReady low for 3 cycles in MEMWR -> State=5 held 4 cycles, MemWrite=1 throughout, then FETCH.
REQ-031 CMP setting Z=1 (Funct=010101), then BNE (Cond=0001, Op=10) -> BRANCH reached, PCWrite=0; with Cond=0000 (BEQ), PCWrite=1.
REQ-032 LDR with Cond=0000 and Z=0 -> MEMADR->MEMRD->FETCH, RegWrite never 1, MemReady ignored.
REQ-033 Assert reset during a MEMWR wait -> MemWrite=0 without a clock edge, State=0, Flags=0000; after release, FETCH holds until MemReady=1.
REQ-034 Sweep all 16 Cond values against all 16 Flags values -> CondEx matches the reference truth table in every case.
